key_load_sequencer: RTL and testbench
=====================================

Name: key_load_sequencer

Overview:
- Configures a key-locked FSM benchmark by loading its key bits from a serial bit-stream handshake.
- Checks the loaded key with an even-parity bit.
- Presents the accepted key as stable parallel key inputs.
- Holds the locked FSM in reset until a good key is committed, then releases it after a fixed hold time.
- Sits between the test/key-delivery interface and the keyinput*/rst pins of the locked FSM.

Parameters:
- KEY_W, 8, number of key bits delivered to the locked FSM (1..32)
- RST_HOLD, 4, cycles fsm_rst stays high after a good key is committed (>=1)
- MAX_FAIL, 3, consecutive parity failures before lockout (used only with KEY_LOCKOUT_EN)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key_start  input  1  one-cycle request to begin a key load
- key_bit_valid  input  1  serial bit valid
- key_bit  input  1  serial key/parity bit
- key_bit_ready  output  1  sequencer accepts a bit this cycle
- key_out  output  KEY_W  committed key; drives the locked FSM keyinputs
- fsm_rst  output  1  reset to the locked FSM
- load_done  output  1  high while a good key is committed and the FSM is released
- load_err  output  1  one-cycle pulse on a parity failure
- locked_out  output  1  lockout flag (constant 0 without KEY_LOCKOUT_EN)

Behaviour:
- Reset values (rst sampled high):
  - outputs: key_out=0, fsm_rst=1, key_bit_ready=0, load_done=0, load_err=0, locked_out=0
  - internals: state=IDLE, shift register=0, bit counter=0, fail counter=0
- Reset applied mid-load aborts the load and returns all outputs to their reset values on the next edge.
- Bit handshake:
  - A bit transfers on a rising edge where key_bit_valid && key_bit_ready.
  - key_bit_ready is a registered output, high only in SHIFT and PARITY.
  - key_bit_valid without ready is ignored; no buffering.
- States:
  - IDLE: fsm_rst=1. key_start -> SHIFT. Next cycle: clear shift register and counter, raise ready.
  - SHIFT:
    - Each transfer shifts key_bit in LSB-first. Bit i lands in position i.
    - Counter increments on each transfer.
    - After the KEY_W-th transfer -> PARITY.
    - key_start is ignored.
  - PARITY: one transfer captures the parity bit. Drop ready -> CHECK.
  - CHECK (one cycle):
    - XOR of all KEY_W bits and the parity bit == 0 -> COMMIT.
    - Otherwise: pulse load_err and increment the fail counter.
      - Without KEY_LOCKOUT_EN -> IDLE.
      - With KEY_LOCKOUT_EN -> LOCKOUT or IDLE, as specified below.
  - COMMIT:
    - key_out <= shift register; fail counter <= 0.
    - fsm_rst stays 1; load hold counter with RST_HOLD.
    - -> RELEASE.
  - RELEASE: fsm_rst=1 for RST_HOLD cycles, counted from the COMMIT edge. Then fsm_rst <= 0 and load_done <= 1 -> DONE.
  - DONE:
    - fsm_rst=0, load_done=1.
    - key_start -> SHIFT, reload path. On that edge fsm_rst <= 1 and load_done <= 0.
    - key_out keeps the old value until the next COMMIT.
- Failure behaviour:
  - On failure, key_out retains its last committed value.
  - fsm_rst stays 1: the FSM is never released on a bad key.
- key_out changes only on the COMMIT edge and is glitch-free: it is fed straight from a register.
- Latency: from the parity-bit transfer edge to fsm_rst falling = 2 + RST_HOLD cycles (CHECK, COMMIT, hold).
- key_start arriving in the same cycle as a bit transfer in IDLE/DONE: the start is taken, and the bit is discarded because ready=0.
- Unreachable state encodings recover to IDLE with reset-equivalent outputs, except that key_out is held.

Optional Feature:
- Macro: KEY_LOCKOUT_EN.
- Defined:
  - When the fail counter reaches MAX_FAIL in CHECK -> LOCKOUT.
  - LOCKOUT: fsm_rst=1, locked_out=1, key_bit_ready=0, key_start ignored.
  - Exit only via rst.
  - Fail counter width = clog2(MAX_FAIL+1); it saturates and does not wrap.
- Not defined:
  - No fail counter and no LOCKOUT state.
  - Unlimited retries; locked_out tied to 0.

Test Plan:
- Good load: rst, then key_start. Send 0xA5 LSB-first (1,0,1,0,0,1,0,1) plus parity 0.
  - key_out=0xA5 on the COMMIT edge.
  - fsm_rst falls exactly 6 cycles after the parity transfer; load_done=1.
- Bad parity: send 0x3C with parity 1.
  - load_err pulses one cycle; key_out stays at its prior value (0 after reset).
  - fsm_rst stays 1; state returns to IDLE.
- Backpressure/valid gaps: deassert key_bit_valid for 3 cycles between bits 2 and 3.
  - Key is still 0xA5, and bit count is unaffected.
  - key_bit_valid asserted in IDLE is ignored.
- Reload from DONE: after a good 0xA5, start a 0x0F load (parity 0).
  - fsm_rst rises on the start edge; key_out stays 0xA5 until COMMIT, then becomes 0x0F.
- Reset mid-SHIFT: assert rst after 4 bits.
  - Next edge: all outputs at reset values; a subsequent full load of 0x81 succeeds.
- KEY_LOCKOUT_EN: three consecutive bad-parity loads.
  - locked_out=1 after the third CHECK; key_start ignored; only rst clears it.
  - A good load between the failures resets the fail counter.

Source files
------------

// File: rtl/key_load_sequencer.sv
// key_load_sequencer: loads a key-locked FSM's key bits from a serial
// stream, checks even parity, then releases the FSM reset after a hold time.
// Optional retry lockout is enabled by defining KEY_LOCKOUT_EN.
module key_load_sequencer #(
    parameter int KEY_W    = 8,
    parameter int RST_HOLD = 4,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_bit_valid,
    input  logic             key_bit,
    output logic             key_bit_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             fsm_rst,
    output logic             load_done,
    output logic             load_err,
    output logic             locked_out
);

    localparam int CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int HW = $clog2(RST_HOLD + 1);

    localparam logic [CW-1:0] LAST_BIT  = CW'(KEY_W - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    // A misconfigured instance never starts a load, so the locked FSM
    // simply stays held in reset.
    localparam bit CFG_OK = (KEY_W >= 1) && (KEY_W <= 32)
                         && (RST_HOLD >= 1) && (MAX_FAIL >= 1);

`ifdef KEY_LOCKOUT_EN
    localparam int FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
    localparam logic [FW-1:0] FAIL_ONE = FW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        PARITY  = 3'd2,
        CHECK   = 3'd3,
        COMMIT  = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6,
        LOCKOUT = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        PARITY  = 3'd2,
        CHECK   = 3'd3,
        COMMIT  = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [KEY_W-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             ready_q, ready_d;
    logic             frst_q, frst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef KEY_LOCKOUT_EN
    logic [FW-1:0]    fail_q, fail_d;
    logic             lock_q, lock_d;
`endif

    logic xfer;
    logic start;
    logic par_bad;

    assign xfer    = key_bit_valid && ready_q;
    assign start   = key_start && CFG_OK;
    assign par_bad = (^shift_q) ^ par_q;

    // Next-state and datapath updates for the load/check/release sequence.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        hold_d  = hold_q;
        key_d   = key_q;
        err_d   = 1'b0;
`ifdef KEY_LOCKOUT_EN
        fail_d  = fail_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    shift_d[cnt_q] = key_bit;
                    cnt_d          = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (xfer) begin
                    par_d   = key_bit;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!par_bad) begin
                    state_d = COMMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
`ifdef KEY_LOCKOUT_EN
                    if (fail_q != FAIL_MAX) begin
                        fail_d = fail_q + FAIL_ONE;
                    end
                    if (fail_d == FAIL_MAX) begin
                        state_d = LOCKOUT;
                    end
`endif
                end
            end
            COMMIT: begin
                key_d   = shift_q;
                hold_d  = HOLD_INIT;
                state_d = RELEASE;
`ifdef KEY_LOCKOUT_EN
                fail_d  = '0;
`endif
            end
            RELEASE: begin
                if (hold_q <= HOLD_ONE) begin
                    state_d = DONE;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
`ifdef KEY_LOCKOUT_EN
            LOCKOUT: begin
                state_d = LOCKOUT;
            end
`endif
            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
                par_d   = 1'b0;
                hold_d  = '0;
`ifdef KEY_LOCKOUT_EN
                fail_d  = '0;
`endif
            end
        endcase
    end

    // Registered outputs follow the state being entered, so they never glitch.
    always_comb begin
        ready_d = (state_d == SHIFT) || (state_d == PARITY);
        frst_d  = (state_d != DONE);
        done_d  = (state_d == DONE);
`ifdef KEY_LOCKOUT_EN
        lock_d  = (state_d == LOCKOUT);
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            hold_q  <= '0;
            key_q   <= '0;
            ready_q <= 1'b0;
            frst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef KEY_LOCKOUT_EN
            fail_q  <= '0;
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            frst_q  <= frst_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef KEY_LOCKOUT_EN
            fail_q  <= fail_d;
            lock_q  <= lock_d;
`endif
        end
    end

    assign key_bit_ready = ready_q;
    assign key_out       = key_q;
    assign fsm_rst       = frst_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
`ifdef KEY_LOCKOUT_EN
    assign locked_out    = lock_q;
`else
    assign locked_out    = 1'b0;
`endif

endmodule

// File: tb/tb_key_load_sequencer.sv
// tb_key_load_sequencer: directed loads checked every cycle against a
// transaction-level model, plus literal checks on key values and latency.
`timescale 1ns/1ps
module tb_key_load_sequencer;

    localparam int KEY_W    = 8;
    localparam int RST_HOLD = 4;
    localparam int MAX_FAIL = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_start;
    logic             key_bit_valid;
    logic             key_bit;
    logic             key_bit_ready;
    logic [KEY_W-1:0] key_out;
    logic             fsm_rst;
    logic             load_done;
    logic             load_err;
    logic             locked_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    key_load_sequencer #(
        .KEY_W   (KEY_W),
        .RST_HOLD(RST_HOLD),
        .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_start    (key_start),
        .key_bit_valid(key_bit_valid),
        .key_bit      (key_bit),
        .key_bit_ready(key_bit_ready),
        .key_out      (key_out),
        .fsm_rst      (fsm_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .locked_out   (locked_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef enum int {M_IDLE, M_LOAD, M_WAIT, M_DONE, M_LOCK} mphase_t;

    mphase_t          ph;
    bit               q[$];
    int               t;
    int               fails;
    bit               par;
    logic [KEY_W-1:0] m_key;
    logic             m_rdy, m_frst, m_done, m_err, m_lock;

    always @(posedge clk) begin
        if (rst) begin
            ph     = M_IDLE;
            q.delete();
            t      = 0;
            fails  = 0;
            m_key  = '0;
            m_rdy  = 1'b0;
            m_frst = 1'b1;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_lock = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_err = 1'b0;
            case (ph)
                M_IDLE, M_DONE: begin
                    if (key_start) begin
                        ph = M_LOAD;
                        q.delete();
                        m_rdy  = 1'b1;
                        m_frst = 1'b1;
                        m_done = 1'b0;
                    end
                end
                M_LOAD: begin
                    if (key_bit_valid) begin
                        q.push_back(key_bit);
                        if (q.size() == KEY_W + 1) begin
                            m_rdy = 1'b0;
                            ph    = M_WAIT;
                            t     = 0;
                        end
                    end
                end
                M_WAIT: begin
                    t++;
                    if (t == 1) begin
                        par = 1'b0;
                        foreach (q[i]) par ^= q[i];
                        if (par) begin
                            m_err = 1'b1;
                            fails++;
                            ph = M_IDLE;
`ifdef KEY_LOCKOUT_EN
                            if (fails >= MAX_FAIL) begin
                                ph     = M_LOCK;
                                m_lock = 1'b1;
                            end
`endif
                        end
                    end else if (t == 2) begin
                        for (int i = 0; i < KEY_W; i++) m_key[i] = q[i];
                        fails = 0;
                    end else if (t == 2 + RST_HOLD) begin
                        m_frst = 1'b0;
                        m_done = 1'b1;
                        ph     = M_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc key_out", key_out, m_key);
            check("cyc ready", key_bit_ready, m_rdy);
            check("cyc fsm_rst", fsm_rst, m_frst);
            check("cyc load_done", load_done, m_done);
            check("cyc load_err", load_err, m_err);
            check("cyc locked_out", locked_out, m_lock);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic with_bit);
        key_start     = 1'b1;
        key_bit_valid = with_bit;
        key_bit       = 1'b1;
        @(negedge clk);
        key_start     = 1'b0;
        key_bit_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        key_bit_valid = 1'b1;
        key_bit       = b;
        while (!key_bit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!key_bit_ready) begin
            checks++;
            errors++;
            $display("FAIL send_bit: ready stuck low at %0t", $time);
        end
        @(negedge clk);
        key_bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [KEY_W-1:0] k, input logic p,
                             input int gap_at, input int gap_len);
        for (int i = 0; i < KEY_W; i++) begin
            if (i == gap_at) repeat (gap_len) @(negedge clk);
            send_bit(k[i]);
        end
        send_bit(p);
    endtask

    task automatic send_key(input logic [KEY_W-1:0] k, input logic p,
                            input int gap_at, input int gap_len);
        pulse_start(1'b0);
        send_bits(k, p, gap_at, gap_len);
    endtask

    // Called at the negedge after the parity transfer.
    task automatic wait_release(input logic [KEY_W-1:0] old_k,
                                input logic [KEY_W-1:0] new_k);
        int n;
        n = 0;
        while (fsm_rst && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) check("key before commit", key_out, old_k);
            if (n == 2) check("key at commit", key_out, new_k);
        end
        check("release latency", n, 6);
        check("load_done after release", load_done, 1);
    endtask

    task automatic bad_load();
        send_key(8'h3C, 1'b1, -1, 0);
        @(negedge clk);
        check("bad load_err pulse", load_err, 1);
        check("bad fsm_rst held", fsm_rst, 1);
        @(negedge clk);
        check("bad load_err drop", load_err, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " key_out"}, key_out, 0);
        check({tag, " fsm_rst"}, fsm_rst, 1);
        check({tag, " ready"}, key_bit_ready, 0);
        check({tag, " load_done"}, load_done, 0);
        check({tag, " load_err"}, load_err, 0);
        check({tag, " locked_out"}, locked_out, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        key_start     = 1'b0;
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Valid in IDLE is ignored.
        key_bit_valid = 1'b1;
        key_bit       = 1'b1;
        repeat (3) @(negedge clk);
        key_bit_valid = 1'b0;
        check("idle ready low", key_bit_ready, 0);

        // Bad parity right after reset: key stays 0.
        send_key(8'h3C, 1'b1, -1, 0);
        @(negedge clk);
        check("bad3C load_err", load_err, 1);
        check("bad3C key_out", key_out, 0);
        @(negedge clk);
        check("bad3C err drop", load_err, 0);
        check("bad3C fsm_rst", fsm_rst, 1);
        check("bad3C ready", key_bit_ready, 0);

        // Good 0xA5 load.
        send_key(8'hA5, 1'b0, -1, 0);
        wait_release(8'h00, 8'hA5);

        // Reload 0x0F from DONE; start cycle also carries a bit.
        pulse_start(1'b1);
        check("reload fsm_rst", fsm_rst, 1);
        check("reload load_done", load_done, 0);
        check("reload key held", key_out, 8'hA5);
        send_bits(8'h0F, 1'b0, -1, 0);
        wait_release(8'hA5, 8'h0F);

        // Valid gap of 3 cycles between bits 2 and 3.
        send_key(8'hA5, 1'b0, 3, 3);
        wait_release(8'h0F, 8'hA5);

        // Reset mid-SHIFT.
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        send_key(8'h81, 1'b0, -1, 0);
        wait_release(8'h00, 8'h81);

        // Fail counter: bad, bad, good clears it, then three bad.
        bad_load();
        bad_load();
        send_key(8'hA5, 1'b0, -1, 0);
        wait_release(8'h81, 8'hA5);
        bad_load();
        check("two fails not locked", locked_out, 0);
        bad_load();
        check("two more fails not locked", locked_out, 0);
        send_key(8'h3C, 1'b1, -1, 0);
        @(negedge clk);
        check("third fail load_err", load_err, 1);
`ifdef KEY_LOCKOUT_EN
        check("third fail locked", locked_out, 1);
`else
        check("third fail not locked", locked_out, 0);
`endif
        check("third fail key kept", key_out, 8'hA5);
        @(negedge clk);
        pulse_start(1'b0);
        @(negedge clk);
`ifdef KEY_LOCKOUT_EN
        check("locked start ignored", key_bit_ready, 0);
        check("locked fsm_rst", fsm_rst, 1);
`else
        check("retry start taken", key_bit_ready, 1);
        send_bits(8'h81, 1'b0, -1, 0);
        wait_release(8'hA5, 8'h81);
`endif
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("final rst");
        rst = 1'b0;
        send_key(8'hA5, 1'b0, -1, 0);
        wait_release(8'h00, 8'hA5);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
